// File: rtl/rvcpu.sv
// Shared CPU-wide constants and types used by the memory-stage blocks.
package rvcpu;

    parameter int unsigned Width = 32;

    typedef logic [31:0] addr_t;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory with byte-lane writes, power-up clear sweep and a sticky fault flag.
// Optional access counters are built only when DATA_MEM_PERF_EN is defined.
module data_mem #(
    parameter int unsigned Depth = 1024,
    parameter int unsigned Width = rvcpu::Width
) (
    input  logic                     clk,
    input  logic                     rst,
    input  rvcpu::addr_t             mem_addr_i,
    input  logic                     mem_re,
    input  logic                     mem_we,
    input  logic [3:0]               mem_w_sel,
    input  logic [Width-1:0]         mem_data_i,
    output logic [Width-1:0]         mem_data_o,
    output logic                     mem_busy_o,
    output logic                     err_o,
    output rvcpu::addr_t             err_addr_o,
    output logic [31:0]              rd_count_o,
    output logic [31:0]              wr_count_o
);

    localparam int unsigned IdxW = $clog2(Depth);

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StReady = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            err_q, err_d;
    rvcpu::addr_t    err_addr_q, err_addr_d;

    logic [Width-1:0] mem_q [Depth];

    logic            ready;
    logic [IdxW-1:0] word_idx;
    logic            aligned;
    logic            in_range;
    logic            legal;
    logic            rd_ok;
    logic            wr_ok;
    logic            fault;

    logic             mem_wr_en;
    logic [IdxW-1:0]  mem_wr_idx;
    logic [Width-1:0] mem_wr_data;
    logic [Width-1:0] mem_wr_mask;

    // Gating on rst keeps the outputs quiet before the first reset edge lands.
    always_comb begin
        ready    = (state_q == StReady) && !rst;
        word_idx = mem_addr_i[IdxW+1:2];
        aligned  = (mem_addr_i[1:0] == 2'b00);
        in_range = ((mem_addr_i >> (IdxW + 2)) == '0);
        legal    = aligned && in_range && !(mem_re && mem_we);
        rd_ok    = ready && mem_re && legal;
        wr_ok    = ready && mem_we && legal;
        fault    = ready && (mem_re || mem_we) && !legal;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;

        if (state_q == StClear) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IdxW'(Depth - 1)) begin
                state_d = StReady;
            end
        end

        // Only the first fault is recorded; later ones leave the address alone.
        if (fault && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = mem_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StClear;
            idx_q      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        mem_wr_en   = 1'b0;
        mem_wr_idx  = '0;
        mem_wr_data = '0;
        mem_wr_mask = '0;
        if (state_q == StClear) begin
            mem_wr_en   = 1'b1;
            mem_wr_idx  = idx_q;
            mem_wr_mask = '1;
        end else if (wr_ok) begin
            mem_wr_en   = 1'b1;
            mem_wr_idx  = word_idx;
            mem_wr_data = mem_data_i;
            for (int i = 0; i < 4; i++) begin
                if (mem_w_sel[i]) begin
                    mem_wr_mask[8*i +: 8] = 8'hFF;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr_en) begin
            mem_q[mem_wr_idx] <= (mem_q[mem_wr_idx] & ~mem_wr_mask) | (mem_wr_data & mem_wr_mask);
        end
    end

    assign mem_data_o = rd_ok ? mem_q[word_idx] : '0;
    assign mem_busy_o = !ready;
    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;

`ifdef DATA_MEM_PERF_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q + {31'd0, rd_ok};
        wr_cnt_d = wr_cnt_q + {31'd0, wr_ok};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;
`else
    assign rd_count_o = '0;
    assign wr_count_o = '0;
`endif

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter Depth, default 1024, number of 32-bit words stored; power of two, at least 4.
REQ-002 SHALL have parameter Width, default rvcpu::Width (32), data word width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 mem_addr_i  input  rvcpu::addr_t  byte address from the memory stage.
REQ-006 mem_re  input  1  read request this cycle.
REQ-007 mem_we  input  1  write request this cycle.
REQ-008 mem_w_sel  input  4  byte-lane write enables; bit i covers bits [8i+7:8i].
REQ-009 mem_data_i  input  Width  write data.
REQ-010 mem_data_o  output  Width  read data, combinational, same cycle as mem_re.
REQ-011 mem_busy_o  output  1  high while the clear sweep runs; accesses are ignored.
REQ-012 err_o  output  1  sticky access-error flag.
REQ-013 err_addr_o  output  rvcpu::addr_t  address of the first faulting access.
REQ-014 rd_count_o, wr_count_o  output  32 each  accepted-access counters (see Configuration).

Function
REQ-015 SHALL implement FSM states CLEAR and READY; rst forces CLEAR with sweep index 0.
REQ-016 In CLEAR: write zero to word[index] each cycle and increment index; after index Depth-1 is written, move to READY on the next edge. The sweep takes exactly Depth cycles after rst deasserts.
REQ-017 mem_busy_o SHALL be 1 exactly while in CLEAR; in CLEAR, mem_data_o=0 and mem_re/mem_we are ignored, with no error and no count.
REQ-018 Word index = mem_addr_i[$clog2(Depth)+1:2]; an access is legal when mem_addr_i[1:0]==0, mem_addr_i < 4*Depth, and not (mem_re & mem_we).
REQ-019 Legal write in READY: on the edge, each byte lane with mem_w_sel[i]=1 takes mem_data_i's byte i; other lanes keep their value; mem_w_sel=0 writes nothing but still counts as a write.
REQ-020 Legal read in READY: mem_data_o = word[index] combinationally; mem_data_o=0 whenever there is no legal read.
REQ-021 Read and write of the same word in the same cycle cannot both be legal (REQ-018); a read after a write returns the new data on the next cycle.
REQ-022 Illegal access in READY (misaligned, out of range, or re&we together): no storage change, mem_data_o=0; if err_o is 0, set err_o=1 and capture err_addr_o=mem_addr_i on the edge.
REQ-023 err_o and err_addr_o SHALL hold until rst; later faults do not overwrite err_addr_o.
REQ-024 A rst asserted mid-sweep or mid-operation SHALL restart the sweep at index 0 on the next edge.

Reset
REQ-025 While rst is high: state=CLEAR, index=0, err_o=0, err_addr_o=0, counters=0, mem_busy_o=1, mem_data_o=0.
REQ-026 Storage contents after reset are defined only through the REQ-016 sweep, which zeroes every word.

Configuration
REQ-027 With macro DATA_MEM_PERF_EN defined: rd_count_o and wr_count_o increment by 1 on each legal read or write accepted in READY; they wrap modulo 2^32.
REQ-028 Without DATA_MEM_PERF_EN: the ports remain present, tied to 0, and no counter registers exist.

Verification
REQ-029 Release rst with Depth=16 -> mem_busy_o high for exactly 16 cycles, then 0; a read of every word returns 0.
REQ-030 Write 0xDEADBEEF to 0x8 with sel=1111, then write 0x000000AA with sel=0001, then read 0x8 -> 0xDEADBEAA.
REQ-031 Read at 0x6 (misaligned), then read at 0x40 with Depth=16 -> mem_data_o=0 both times; err_o=1; err_addr_o=0x6.
REQ-032 re=we=1 at 0x4 carrying data 0x1234 -> no write (a later read of 0x4 returns its prior value), err_o set if clear.
REQ-033 Assert rst at sweep index 7 -> sweep restarts and mem_busy_o stays high for a further full Depth cycles.
REQ-034 With DATA_MEM_PERF_EN: 3 legal reads, 2 legal writes and 1 illegal access -> rd_count_o=3, wr_count_o=2; without the macro, both read 0.
